reg_writeback_unit: RTL and testbench
=====================================

Name: reg_writeback_unit

Overview:
- Write-side companion of the register file. Merges single-cycle ALU results and multi-cycle load completions into the file's single write port.
- Buffers load completions in a small FIFO and prevents load starvation.
- Keeps a per-register pending-load scoreboard that decode uses for hazard stalls.
- Sits between the EX/MEM pipeline plus memory controller and the register file's w_enable/w_addr/w_data inputs.

Parameters:
- DEPTH, 4, load-result FIFO entries (power of two, minimum 2)
- STARVE_MAX, 3, consecutive cycles a non-empty FIFO may lose to the ALU before forced drain
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, synchronous, active-high
- alu_valid  input  1  ALU result present this cycle
- alu_ready  output  1  ALU result accepted this cycle; upstream holds alu_* while low
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- ld_valid  input  1  load completion present
- ld_ready  output  1  load FIFO can accept
- ld_addr  input  ADDR_W  load destination register
- ld_data  input  DATA_W  load data
- issue_valid  input  1  a load with destination issue_addr issues this cycle
- issue_addr  input  ADDR_W  destination of issued load
- w_enable  output  1  register file write enable, registered
- w_addr  output  ADDR_W  register file write address, registered
- w_data  output  DATA_W  register file write data, registered
- pending  output  2**ADDR_W  scoreboard bit per register, registered
- fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: w_enable=0, w_addr=0, w_data=0, pending=0, fifo_count=0, FIFO pointers=0, starvation counter=0.
- While rst=1:
  - ld_ready=0, alu_ready=0.
  - No enqueue, no write, no scoreboard change.
  - Reset mid-operation discards all FIFO contents.
- Handshakes:
  - Load transfer occurs on a cycle with ld_valid & ld_ready.
  - ALU transfer occurs on a cycle with alu_valid & alu_ready.
  - ld_ready = !rst & (fifo_count < DEPTH). It depends on count only; no same-cycle bypass when full.
- Write-port arbitration, decided each cycle, with one write per cycle:
  - FORCE: FIFO non-empty and starve_cnt == STARVE_MAX. Dequeue the FIFO head and drive the write; alu_ready=0.
  - ALU: otherwise, if alu_valid. alu_ready=1 and the ALU result is written.
  - DRAIN: otherwise, if FIFO non-empty. Dequeue the head and write it.
  - IDLE: otherwise. No write.
  - alu_ready = !rst & !FORCE; it is high even when alu_valid=0.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on cycles where the FIFO is non-empty and the ALU wins.
  - Clears on any dequeue, or when the FIFO is empty.
- Latency:
  - The selected source appears on w_enable/w_addr/w_data on the next rising edge, for exactly one cycle.
  - Minimum load latency from ld transfer to w_enable is 2 cycles (enqueue, then dequeue). There is no FIFO bypass.
- x0 handling:
  - A selected write with addr 0 still consumes its slot and is dequeued/accepted.
  - It drives w_enable=0; w_addr/w_data hold their previous values.
  - A load to x0 is enqueued normally.
- FIFO behaviour:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Simultaneous enqueue and dequeue leaves the count unchanged.
  - Order is strictly FIFO.
- Scoreboard:
  - An issue_valid with issue_addr≠0 sets pending[issue_addr] on the next edge.
  - A load dequeue with addr≠0 clears that bit on the same edge as the write is registered.
  - Simultaneous set and clear of the same bit: set wins (a newer load is outstanding).
  - pending[0] is always 0.
  - ALU writes never touch pending.
- Intended usage:
  - Decode stalls on pending[rs]; the register file's internal forwarding covers the cycle w_enable is high.
  - This block does not forward.

Test Plan:
- Reset then idle: assert rst 2 cycles with ld_valid=1 → w_enable=0, pending=0, ld_ready=0, fifo_count=0; after release ld_ready=1, alu_ready=1.
- ALU only: alu_valid=1, addr=5, data=0xDEADBEEF at cycle N → w_enable=1, w_addr=5, w_data=0xDEADBEEF at N+1 only; alu addr=0 → w_enable stays 0.
- Load path and scoreboard: issue addr=7 at cycle 0 → pending[7]=1 from cycle 1; ld addr=7, data=0x12345678 at cycle 3, ALU idle → write registered at cycle 5 (2-cycle minimum latency), pending[7]=0 at cycle 5. Issue addr=7 again in the dequeue cycle → pending[7] stays 1.
- FIFO full: hold alu_valid=1 and push 5 loads back-to-back with DEPTH=4 → ld_ready=0 once fifo_count=4. Loads drain in push order (0xA0,0xA1,...), interleaved by forced drains.
- Starvation: one queued load plus continuous alu_valid → ALU wins 3 cycles, 4th cycle alu_ready=0 and the load is written. The ALU value held in that cycle is written the following cycle; the counter returns to 0.
- Reset mid-operation: FIFO holding 3 entries, pending bits 3 and 9 set, rst=1 for 1 cycle → fifo_count=0, pending=0, and no w_enable pulses from the discarded entries.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// Write-side companion of the register file: merges ALU results and buffered load
// completions onto the single write port and tracks pending loads per register.
module reg_writeback_unit #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 3,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_valid_i,
   output logic                      alu_ready_o,
   input  logic [ADDR_W-1:0]         alu_addr_i,
   input  logic [DATA_W-1:0]         alu_data_i,
   input  logic                      ld_valid_i,
   output logic                      ld_ready_o,
   input  logic [ADDR_W-1:0]         ld_addr_i,
   input  logic [DATA_W-1:0]         ld_data_i,
   input  logic                      issue_valid_i,
   input  logic [ADDR_W-1:0]         issue_addr_i,
   output logic                      w_enable_o,
   output logic [ADDR_W-1:0]         w_addr_o,
   output logic [DATA_W-1:0]         w_data_o,
   output logic [2**ADDR_W-1:0]      pending_o,
   output logic [$clog2(DEPTH):0]    fifo_count_o
);

   localparam int unsigned PtrW    = $clog2(DEPTH);
   localparam int unsigned CntW    = PtrW + 1;
   localparam int unsigned NumRegs = 2 ** ADDR_W;
   localparam int unsigned StarveW = $clog2(STARVE_MAX + 2);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);
   localparam logic [CntW-1:0]    DepthCnt  = CntW'(DEPTH);

   logic [ADDR_W-1:0]  fifo_addr_q [DEPTH];
   logic [DATA_W-1:0]  fifo_data_q [DEPTH];
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    count_q, count_d;
   logic [StarveW-1:0] starve_q, starve_d;
   logic [NumRegs-1:0] pending_q, pending_d;
   logic               w_enable_q;
   logic [ADDR_W-1:0]  w_addr_q;
   logic [DATA_W-1:0]  w_data_q;

   logic               fifo_empty;
   logic               force_drain;
   logic               alu_sel;
   logic               deq;
   logic               enq;
   logic               wr_go;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   always_comb begin
      fifo_empty  = (count_q == '0);
      force_drain = !fifo_empty && (starve_q == StarveMax);
      alu_ready_o = !rst && !force_drain;
      ld_ready_o  = !rst && (count_q < DepthCnt);
      alu_sel     = alu_valid_i && alu_ready_o;
      // The FIFO wins only when forced or when the ALU has nothing to offer.
      deq         = !rst && !fifo_empty && (force_drain || !alu_valid_i);
      enq         = ld_valid_i && ld_ready_o;
      head_addr   = fifo_addr_q[rd_ptr_q];
      head_data   = fifo_data_q[rd_ptr_q];
      sel_addr    = deq ? head_addr : alu_addr_i;
      sel_data    = deq ? head_data : alu_data_i;
      wr_go       = (deq || alu_sel) && (sel_addr != '0);

      wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (enq && !deq) begin
         count_d = count_q + CntW'(1);
      end else if (deq && !enq) begin
         count_d = count_q - CntW'(1);
      end

      starve_d = starve_q;
      if (deq || fifo_empty) begin
         starve_d = '0;
      end else if (alu_sel && (starve_q != StarveMax)) begin
         starve_d = starve_q + StarveW'(1);
      end

      // Set is applied after clear so a newly issued load keeps its bit.
      pending_d = pending_q;
      if (deq) begin
         pending_d[head_addr] = 1'b0;
      end
      if (issue_valid_i) begin
         pending_d[issue_addr_i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_addr_q[wr_ptr_q] <= ld_addr_i;
         fifo_data_q[wr_ptr_q] <= ld_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         pending_q  <= '0;
         w_enable_q <= 1'b0;
         w_addr_q   <= '0;
         w_data_q   <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         pending_q  <= pending_d;
         w_enable_q <= wr_go;
         if (wr_go) begin
            w_addr_q <= sel_addr;
            w_data_q <= sel_data;
         end
      end
   end

   assign w_enable_o   = w_enable_q;
   assign w_addr_o     = w_addr_q;
   assign w_data_o     = w_data_q;
   assign pending_o    = pending_q;
   assign fifo_count_o = count_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: a queue-based model predicts every
// register-file write, the readies, occupancy and the pending scoreboard.
module tb_reg_writeback_unit;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned STARVE_MAX = 3;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 5;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      int unsigned       due;
   } wr_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   alu_valid = 1'b0;
   logic                   alu_ready;
   logic [ADDR_W-1:0]      alu_addr = '0;
   logic [DATA_W-1:0]      alu_data = '0;
   logic                   ld_valid = 1'b0;
   logic                   ld_ready;
   logic [ADDR_W-1:0]      ld_addr = '0;
   logic [DATA_W-1:0]      ld_data = '0;
   logic                   issue_valid = 1'b0;
   logic [ADDR_W-1:0]      issue_addr = '0;
   logic                   w_enable;
   logic [ADDR_W-1:0]      w_addr;
   logic [DATA_W-1:0]      w_data;
   logic [2**ADDR_W-1:0]   pending;
   logic [$clog2(DEPTH):0] fifo_count;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;

   // Reference model state
   wr_t               lq[$];
   wr_t               exq[$];
   int unsigned       starve_m = 0;
   logic [31:0]       pend_m = '0;
   logic              ld_acc, alu_acc;
   logic [ADDR_W-1:0] last_a = '0;
   logic [DATA_W-1:0] last_d = '0;

   reg_writeback_unit #(
      .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst),
      .alu_valid_i(alu_valid), .alu_ready_o(alu_ready),
      .alu_addr_i(alu_addr), .alu_data_i(alu_data),
      .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
      .ld_addr_i(ld_addr), .ld_data_i(ld_data),
      .issue_valid_i(issue_valid), .issue_addr_i(issue_addr),
      .w_enable_o(w_enable), .w_addr_o(w_addr), .w_data_o(w_data),
      .pending_o(pending), .fifo_count_o(fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock cycle: check registered state, drive inputs, predict, advance.
   task automatic step(input logic r, input logic av, input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] ad, input logic lv,
                       input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ldd,
                       input logic iv, input logic [ADDR_W-1:0] ia);
      int unsigned sz;
      logic        empty, frc, deq, won;
      wr_t         e;
      @(negedge clk);
      chk("fifo_count", 64'(fifo_count), 64'(lq.size()));
      chk("pending", 64'(pending), 64'(pend_m));
      rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
      ld_valid = lv; ld_addr = la; ld_data = ldd; issue_valid = iv; issue_addr = ia;
      #1;
      ld_acc = 1'b0; alu_acc = 1'b0;
      if (r) begin
         chk("alu_ready_rst", 64'(alu_ready), 64'(0));
         chk("ld_ready_rst", 64'(ld_ready), 64'(0));
         lq.delete();
         starve_m = 0;
         pend_m = '0;
      end else begin
         sz = lq.size();
         empty = (sz == 0);
         frc = !empty && (starve_m == STARVE_MAX);
         deq = 1'b0; won = 1'b0;
         chk("alu_ready", 64'(alu_ready), 64'(!frc));
         chk("ld_ready", 64'(ld_ready), 64'(sz < DEPTH));
         e = '0;
         if (frc || (!av && !empty)) begin
            e = lq.pop_front();
            deq = 1'b1;
         end else if (av) begin
            e.a = aa; e.d = ad;
            won = 1'b1;
            alu_acc = 1'b1;
         end
         if ((deq || won) && e.a != 0) begin
            e.due = cyc + 1;
            exq.push_back(e);
         end
         if (lv && sz < DEPTH) begin
            lq.push_back('{a: la, d: ldd, due: 0});
            ld_acc = 1'b1;
         end
         if (deq || empty) starve_m = 0;
         else if (won && starve_m < STARVE_MAX) starve_m++;
         if (deq && e.a != 0) pend_m[e.a] = 1'b0;
         if (iv && ia != 0) pend_m[ia] = 1'b1;
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every write must match the oldest prediction on its due cycle.
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            last_a = '0; last_d = '0;
         end
         if (w_enable) begin
            if (exq.size() == 0) begin
               chk("unexpected_write", 64'(w_addr), 64'hFFFF_FFFF_FFFF);
            end else begin
               e = exq.pop_front();
               chk("w_addr", 64'(w_addr), 64'(e.a));
               chk("w_data", 64'(w_data), 64'(e.d));
               chk("w_due", 64'(cyc), 64'(e.due));
               last_a = e.a; last_d = e.d;
            end
         end else begin
            if (exq.size() > 0 && exq[0].due <= cyc) begin
               e = exq.pop_front();
               chk("missing_write", 64'(0), 64'(1));
            end
            chk("w_addr_hold", 64'(w_addr), 64'(last_a));
            chk("w_data_hold", 64'(w_data), 64'(last_d));
         end
      end
   end

   initial begin
      int          idx;
      int unsigned k;
      logic        av, hold;
      logic [ADDR_W-1:0] aa;
      logic [DATA_W-1:0] ad;

      // Reset with a load offered: nothing may be accepted.
      step(1, 0, 0, 0, 1, 3, 32'h55, 0, 0);
      step(1, 0, 0, 0, 1, 3, 32'h55, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ALU only, then an ALU write to x0.
      step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      step(0, 1, 0, 32'h1111_2222, 0, 0, 0, 0, 0);
      idle(2);

      // Load path with scoreboard, then re-issue in the dequeue cycle.
      step(0, 0, 0, 0, 0, 0, 0, 1, 7);
      idle(2);
      step(0, 0, 0, 0, 1, 7, 32'h1234_5678, 0, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 0, 0, 1, 7);
      step(0, 0, 0, 0, 1, 7, 32'h8765_4321, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 7);
      idle(3);

      // FIFO fill under constant ALU pressure.
      idx = 0; k = 0;
      for (int i = 0; i < 24; i++) begin
         step(0, 1, 5'(10 + (k % 4)), 32'hB000 + k, idx < 5, 5'(20 + idx),
              32'hA0 + idx, 0, 0);
         if (ld_acc) idx++;
         if (alu_acc) k++;
      end
      idle(6);

      // Starvation: one queued load against continuous ALU traffic.
      step(0, 0, 0, 0, 1, 12, 32'hCAFE, 1, 12);
      k = 0;
      for (int i = 0; i < 7; i++) begin
         step(0, 1, 6, 32'hC000 + k, 0, 0, 0, 0, 0);
         if (alu_acc) k++;
      end
      idle(3);

      // Reset mid-operation with three loads queued and two pending bits.
      step(0, 1, 4, 32'h40, 1, 3, 32'h300, 1, 3);
      step(0, 1, 4, 32'h41, 1, 9, 32'h900, 1, 9);
      step(0, 1, 4, 32'h42, 1, 3, 32'h301, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(6);

      // Random traffic; the ALU side holds its payload until accepted.
      hold = 1'b0; av = 1'b0; aa = '0; ad = '0;
      for (int i = 0; i < 600; i++) begin
         if (!hold) begin
            av = ($urandom_range(0, 99) < 60);
            aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            ad = $urandom;
         end
         step(($urandom_range(0, 99) == 0), av, aa, ad,
              ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom,
              ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)));
         hold = av && !alu_acc && !rst;
      end
      idle(12);
      @(negedge clk);
      chk("writes_outstanding", 64'(exq.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
